// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (owner select, stats width,
// default bus widths, saturating increment helper).
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_AUX  = 1'b1
  } owner_t;

  localparam int STAT_W = 16;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int WCNT_W = 4;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core, the auxiliary requester, the arbiter and the data memory.
// Handshake: aux_req is held with aux_we/aux_addr/aux_wdata until aux_gnt is seen high in a cycle; core holds its request while core_stall is high; mem_rdata is combinational.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_gnt;
  logic          aux_rvalid;
  logic [DW-1:0] aux_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_stats.sv
// Saturating activity counters for the data-memory arbiter: served core accesses,
// aux grants and core stall cycles. Present only when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              core_acc,
  input  logic              aux_gnt,
  input  logic              core_stall,
  output logic [STAT_W-1:0] stat_core,
  output logic [STAT_W-1:0] stat_aux,
  output logic [STAT_W-1:0] stat_stall
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_core  <= '0;
      stat_aux   <= '0;
      stat_stall <= '0;
    end else begin
      if (core_acc)   stat_core  <= sat_inc(stat_core);
      if (aux_gnt)    stat_aux   <= sat_inc(stat_aux);
      if (core_stall) stat_stall <= sat_inc(stat_stall);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the shared data-memory port with bounded aux starvation.
// Optional statistics counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus,
  output owner_t            dbg_owner,
  output logic [WCNT_W-1:0] dbg_wait_cnt
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_core,
  output logic [STAT_W-1:0] stat_aux,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

  owner_t            owner;
  logic [WCNT_W-1:0] wait_cnt;
  logic              gnt;
  logic              stall;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;

  // Aux wins when the core is idle or once it has waited MAX_WAIT busy cycles.
  always_comb begin
    owner = OWN_CORE;
    if (!rst && bus.aux_req && (!bus.core_req || wait_cnt == WAIT_MAX))
      owner = OWN_AUX;
  end

  assign gnt   = (owner == OWN_AUX);
  assign stall = gnt && bus.core_req;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = bus.core_addr;
    sel_wdata = bus.core_wdata;
    if (gnt) begin
      sel_we    = bus.aux_we;
      sel_addr  = bus.aux_addr;
      sel_wdata = bus.aux_wdata;
    end else if (!rst) begin
      sel_we = bus.core_we && bus.core_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (gnt || !bus.aux_req)
        wait_cnt <= '0;
      else if (bus.core_req && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WCNT_W'(1);
      rvalid_q <= gnt && !bus.aux_we;
      if (gnt && !bus.aux_we)
        rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_we     = sel_we;
  assign bus.mem_addr   = sel_addr;
  assign bus.mem_wdata  = sel_wdata;
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.core_stall = stall;
  assign bus.aux_gnt    = gnt;
  // A reset in the cycle after a read grant must hide the pending pulse.
  assign bus.aux_rvalid = rvalid_q && !rst;
  assign bus.aux_rdata  = rdata_q;
  assign dbg_owner      = owner;
  assign dbg_wait_cnt   = wait_cnt;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .core_acc   (bus.core_req && !stall && !rst),
    .aux_gnt    (gnt),
    .core_stall (stall),
    .stat_core  (stat_core),
    .stat_aux   (stat_aux),
    .stat_stall (stat_stall)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed data memory model.
// Statistics checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  owner_t            dbg_owner;
  logic [WCNT_W-1:0] dbg_wait_cnt;
`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_core;
  logic [STAT_W-1:0] stat_aux;
  logic [STAT_W-1:0] stat_stall;
`endif

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_owner    (dbg_owner),
    .dbg_wait_cnt (dbg_wait_cnt)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core    (stat_core),
    .stat_aux     (stat_aux),
    .stat_stall   (stat_stall)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: combinational read, write on the rising edge
  logic [31:0] mem [0:255];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with both requesters asserting stores
    rst = 1'b1;
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h10; bus.core_wdata = 32'hdead;
    bus.aux_req  = 1'b1; bus.aux_we  = 1'b1; bus.aux_addr  = 32'h20; bus.aux_wdata  = 32'hbeef;
    #1;
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_gnt", 32'(bus.aux_gnt), 32'h0);
    check("rst_stall", 32'(bus.core_stall), 32'h0);
    tick();
    check("rst_mem_we2", 32'(bus.mem_we), 32'h0);
    check("rst_gnt2", 32'(bus.aux_gnt), 32'h0);
    check("rst_stall2", 32'(bus.core_stall), 32'h0);
    check("rst_rvalid", 32'(bus.aux_rvalid), 32'h0);
    check("rst_rdata", bus.aux_rdata, 32'h0);
    check("rst_wait", 32'(dbg_wait_cnt), 32'h0);
    tick();
    rst = 1'b0;
    bus.core_req = 1'b0; bus.aux_req = 1'b0;

    // idle core: aux write granted in the same cycle
    bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 32'h10; bus.aux_wdata = 32'h41;
    #1;
    check("idle_gnt", 32'(bus.aux_gnt), 32'h1);
    check("idle_mem_we", 32'(bus.mem_we), 32'h1);
    check("idle_mem_addr", bus.mem_addr, 32'h10);
    check("idle_mem_wdata", bus.mem_wdata, 32'h41);
    check("idle_stall", 32'(bus.core_stall), 32'h0);
    tick();
    bus.aux_req = 1'b0;
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h20; bus.core_wdata = 32'h1234;
    #1;
    check("core_st_we", 32'(bus.mem_we), 32'h1);
    check("core_st_gnt", 32'(bus.aux_gnt), 32'h0);
    check("aux_wr_no_rvalid", 32'(bus.aux_rvalid), 32'h0);
    tick();
    bus.core_we = 1'b0; bus.core_addr = 32'h10;
    #1;
    check("core_ld_rdata", bus.core_rdata, 32'h41);
    check("core_ld_stall", 32'(bus.core_stall), 32'h0);
    check("core_ld_we", 32'(bus.mem_we), 32'h0);
    tick();

    // contention: core busy reading 0x10, aux reads 0x20
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 32'h20;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("cont_gnt_%0d", c), 32'(bus.aux_gnt), (c == 4) ? 32'h1 : 32'h0);
      check($sformatf("cont_stall_%0d", c), 32'(bus.core_stall), (c == 4) ? 32'h1 : 32'h0);
      check($sformatf("cont_wait_%0d", c), 32'(dbg_wait_cnt), 32'(c));
      check($sformatf("cont_addr_%0d", c), bus.mem_addr, (c == 4) ? 32'h20 : 32'h10);
      tick();
    end
    bus.aux_req = 1'b0;
    #1;
    check("cont_rvalid", 32'(bus.aux_rvalid), 32'h1);
    check("cont_rdata", bus.aux_rdata, 32'h1234);
    check("cont_stall_after", 32'(bus.core_stall), 32'h0);
    tick();
    check("cont_rvalid_off", 32'(bus.aux_rvalid), 32'h0);

    // continuous traffic: aux every fifth cycle
    bus.aux_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("cont20_gnt_%0d", c), 32'(bus.aux_gnt), (c % 5 == 4) ? 32'h1 : 32'h0);
      check($sformatf("cont20_stall_%0d", c), 32'(bus.core_stall), (c % 5 == 4) ? 32'h1 : 32'h0);
      tick();
    end

    // reset mid-wait discards the accumulated wait
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("mid_wait_%0d", c), 32'(dbg_wait_cnt), 32'(c));
      tick();
    end
    check("mid_wait_3", 32'(dbg_wait_cnt), 32'h3);
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(bus.aux_gnt), 32'h0);
    check("mid_rst_stall", 32'(bus.core_stall), 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("post_rst_gnt_%0d", k), 32'(bus.aux_gnt), (k == 4) ? 32'h1 : 32'h0);
      check($sformatf("post_rst_wait_%0d", k), 32'(dbg_wait_cnt), 32'(k));
      tick();
    end
    // reset in the cycle after a read grant hides aux_rvalid
    rst = 1'b1;
    #1;
    check("rst_suppress_rvalid", 32'(bus.aux_rvalid), 32'h0);
    tick();
    rst = 1'b0;
    bus.aux_req = 1'b0; bus.core_req = 1'b0;
    tick();

`ifdef DMEM_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stat_core_rst", 32'(stat_core), 32'h0);
    bus.core_req = 1'b1; bus.aux_req = 1'b1; bus.aux_we = 1'b0;
    repeat (10) tick();
    bus.core_req = 1'b0; bus.aux_req = 1'b0;
    #1;
    check("stat_core", 32'(stat_core), 32'h8);
    check("stat_aux", 32'(stat_aux), 32'h2);
    check("stat_stall", 32'(stat_stall), 32'h2);
    bus.core_req = 1'b1;
    repeat (70000) tick();
    bus.core_req = 1'b0;
    check("stat_core_sat", 32'(stat_core), 32'hffff);
    check("stat_aux_hold", 32'(stat_aux), 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
